// File: rtl/sram_arb_multi_if.sv
// Master-side bundle for sram_arb_multi: per-master request/response buses plus lock and status.
// Masters drive requests and lock; the arbiter drives waitrequest, read data and status.
interface sram_arb_multi_if #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MASTERS = 4,
  parameter int SEL_WIDTH   = 2
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                              lock_en;
  logic [SEL_WIDTH-1:0]              lock_sel;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address;
  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_byteenable;
  logic [NUM_MASTERS-1:0]            m_read;
  logic [NUM_MASTERS-1:0]            m_write;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_writedata;
  logic [NUM_MASTERS-1:0]            m_waitrequest;
  logic [DATA_WIDTH-1:0]             m_readdata;
  logic [NUM_MASTERS-1:0]            m_readdataready;
  logic                              busy;
  logic [SEL_WIDTH-1:0]              grant_id;

  modport master (
    output lock_en, lock_sel, m_address, m_byteenable, m_read, m_write, m_writedata,
    input  m_waitrequest, m_readdata, m_readdataready, busy, grant_id
  );

  modport slave (
    input  lock_en, lock_sel, m_address, m_byteenable, m_read, m_write, m_writedata,
    output m_waitrequest, m_readdata, m_readdataready, busy, grant_id
  );
endinterface

// File: rtl/sram_arb_multi.sv
// N-master arbiter/controller for an async SRAM; read data returns RD_WAIT+1 cycles after accept,
// writes free the bus WR_WAIT+2 cycles after accept. Non-winning masters see waitrequest held high.
module sram_arb_multi #(
  parameter int ADDR_WIDTH  = 20,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MASTERS = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int ARB_MODE    = 1,
  parameter int RD_WAIT     = 2,
  parameter int WR_WAIT     = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  sram_arb_multi_if.slave         bus,
  output logic [ADDR_WIDTH-1:0]   sram_address,
  inout  wire  [DATA_WIDTH-1:0]   sram_data,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n,
  output logic [DATA_WIDTH/8-1:0] sram_be_n
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, WR_HOLD} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic [3:0]              w_cnt_nxt;
  logic [NUM_MASTERS-1:0]  w_req;
  logic [SEL_WIDTH-1:0]    w_win;
  logic                    w_any;
  logic                    w_accept;
  logic                    w_acc_wr;
  logic                    w_rd_done;
  logic [NUM_MASTERS-1:0]  w_waitreq;

  logic [SEL_WIDTH-1:0]    r_last;
  logic [SEL_WIDTH-1:0]    r_grant;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [BE_WIDTH-1:0]     r_be_n;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [NUM_MASTERS-1:0]  r_rdv;
  logic                    r_ce_n;
  logic                    r_oe_n;
  logic                    r_we_n;
  logic                    r_drv;

  // Lock masks every master but lock_sel; an out-of-range lock_sel matches nobody.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_req[i] = (bus.m_read[i] | bus.m_write[i]) &
                 (~bus.lock_en | (int'(bus.lock_sel) == i));
    end
  end

  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_req[i] && !w_any) begin
          w_win = SEL_WIDTH'(i);
          w_any = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_MASTERS; k++) begin
        if (w_req[(int'(r_last) + k) % NUM_MASTERS] && !w_any) begin
          w_win = SEL_WIDTH'((int'(r_last) + k) % NUM_MASTERS);
          w_any = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_acc_wr    = 1'b0;
    w_rd_done   = 1'b0;
    w_waitreq   = '1;
    case (r_state)
      IDLE: begin
        if (w_any && reset_n) begin
          w_accept         = 1'b1;
          w_waitreq[w_win] = 1'b0;
          w_acc_wr         = bus.m_write[w_win];
          w_state_nxt      = w_acc_wr ? WR : RD;
          w_cnt_nxt        = '0;
        end
      end
      RD: begin
        if (r_cnt == 4'(RD_WAIT - 1)) begin
          w_rd_done   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      WR: begin
        if (r_cnt == 4'(WR_WAIT - 1)) begin
          w_state_nxt = WR_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      WR_HOLD: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes and bus drive are registered decodes of the next state, so they track the state exactly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last  <= SEL_WIDTH'(NUM_MASTERS - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_be_n  <= '1;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rdv   <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_drv   <= 1'b0;
    end else begin
      r_rdv <= '0;
      if (w_accept) begin
        r_addr  <= bus.m_address[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
        r_be_n  <= ~bus.m_byteenable[int'(w_win)*BE_WIDTH +: BE_WIDTH];
        r_wdata <= bus.m_writedata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
        r_grant <= w_win;
        r_last  <= w_win;
      end
      if (w_rd_done) begin
        r_rdata        <= sram_data;
        r_rdv[r_grant] <= 1'b1;
      end
      r_ce_n <= (w_state_nxt == IDLE);
      r_oe_n <= (w_state_nxt != RD);
      r_we_n <= (w_state_nxt != WR);
      r_drv  <= (w_state_nxt == WR) || (w_state_nxt == WR_HOLD);
    end
  end

  assign sram_data           = r_drv ? r_wdata : {DATA_WIDTH{1'bz}};
  assign sram_address        = r_addr;
  assign sram_be_n           = r_be_n;
  assign sram_ce_n           = r_ce_n;
  assign sram_oe_n           = r_oe_n;
  assign sram_we_n           = r_we_n;
  assign bus.m_waitrequest   = w_waitreq;
  assign bus.m_readdata      = r_rdata;
  assign bus.m_readdataready = r_rdv;
  assign bus.busy            = (r_state != IDLE);
  assign bus.grant_id        = r_grant;
endmodule

// File: tb/tb_sram_arb_multi.sv
// Bench for sram_arb_multi: directed scenarios plus random multi-master traffic against a
// transaction-timing model of the arbiter and a reference memory.
module tb_sram_arb_multi;
  localparam int AW  = 20;
  localparam int DW  = 16;
  localparam int NM  = 4;
  localparam int SW  = 2;
  localparam int ARB = 1;
  localparam int RW  = 2;
  localparam int WW  = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-1:0] sram_address;
  wire  [DW-1:0] sram_data;
  logic sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0] sram_be_n;

  sram_arb_multi_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(NM), .SEL_WIDTH(SW)) bus();

  sram_arb_multi #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(NM), .SEL_WIDTH(SW),
                   .ARB_MODE(ARB), .RD_WAIT(RW), .WR_WAIT(WW)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus),
    .sram_address(sram_address), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // SRAM device model and reference memory; unwritten words read as addr ^ 0xA5A5.
  logic [15:0] sram_mem [logic [19:0]];
  logic [15:0] ref_mem  [logic [19:0]];
  logic [15:0] sram_rd = 16'h0;

  function automatic logic [15:0] sram_get(input logic [19:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic logic [15:0] ref_get(input logic [19:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign sram_data = (!sram_ce_n && !sram_oe_n) ? sram_rd : 16'hzzzz;

  initial begin
    forever begin
      @(negedge clock);
      sram_rd = sram_get(sram_address);
    end
  end

  initial begin
    logic [15:0] w;
    forever begin
      @(posedge clock);
      if (reset_n && !sram_ce_n && !sram_we_n) begin
        w = sram_get(sram_address);
        for (int b = 0; b < 2; b++) if (!sram_be_n[b]) w[b*8 +: 8] = sram_data[b*8 +: 8];
        sram_mem[sram_address] = w;
      end
    end
  end

  // Transaction model: one outstanding transfer, timing derived from the accept cycle.
  int            cyc = 0;
  logic          have = 1'b0;
  int            t_acc = 0;
  logic          m_wr = 1'b0;
  int            owner = 0;
  logic [19:0]   m_addr = '0;
  logic [1:0]    m_be = '0;
  logic [1:0]    m_be_n = '1;
  logic [15:0]   m_dat = '0;
  logic [15:0]   m_exp_rd = '0;
  int            last = NM - 1;
  int            exp_grant = 0;
  logic [NM-1:0] acc_mask = '0;
  int            m_dur;
  logic          m_busy;
  logic [NM-1:0] m_req, m_rdy, m_wait;
  int            g;
  logic [15:0]   nw;

  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      acc_mask = '0;
      if (!reset_n) begin
        have = 1'b0;
        last = NM - 1;
        exp_grant = 0;
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_be_n", 32'(sram_be_n), 32'h3);
        check("rst_addr", 32'(sram_address), 32'd0);
        check("rst_wait", 32'(bus.m_waitrequest), 32'hF);
        check("rst_rdy", 32'(bus.m_readdataready), 32'd0);
        check("rst_rdata", 32'(bus.m_readdata), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant", 32'(bus.grant_id), 32'd0);
      end else begin
        m_dur  = m_wr ? WW + 1 : RW;
        m_busy = have && (cyc <= t_acc + m_dur);
        m_rdy  = '0;
        if (have && !m_wr && cyc == t_acc + RW + 1) m_rdy[owner] = 1'b1;
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("ce_n", 32'(sram_ce_n), 32'(!m_busy));
        check("oe_n", 32'(sram_oe_n), 32'(!(m_busy && !m_wr)));
        check("we_n", 32'(sram_we_n), 32'(!(have && m_wr && cyc <= t_acc + WW)));
        check("rdy", 32'(bus.m_readdataready), 32'(m_rdy));
        check("grant_id", 32'(bus.grant_id), 32'(exp_grant));
        if (m_rdy != 0) check("readdata", 32'(bus.m_readdata), 32'(m_exp_rd));
        if (m_busy) begin
          check("sram_addr", 32'(sram_address), 32'(m_addr));
          check("sram_be_n", 32'(sram_be_n), 32'(m_be_n));
          if (m_wr) check("sram_wdata", 32'(sram_data), 32'(m_dat));
        end
        m_wait = '1;
        g = -1;
        if (!m_busy) begin
          for (int i = 0; i < NM; i++)
            m_req[i] = (bus.m_read[i] | bus.m_write[i]) &&
                       (!bus.lock_en || int'(bus.lock_sel) == i);
          if (ARB == 0) begin
            for (int i = NM - 1; i >= 0; i--) if (m_req[i]) g = i;
          end else begin
            for (int k = NM; k >= 1; k--) if (m_req[(last + k) % NM]) g = (last + k) % NM;
          end
          if (g >= 0) begin
            m_wait[g] = 1'b0;
            acc_mask[g] = 1'b1;
          end
        end
        check("waitreq", 32'(bus.m_waitrequest), 32'(m_wait));
        if (g >= 0) begin
          have      = 1'b1;
          t_acc     = cyc;
          owner     = g;
          last      = g;
          exp_grant = g;
          m_wr      = bus.m_write[g];
          m_addr    = bus.m_address[g*AW +: AW];
          m_be      = bus.m_byteenable[g*2 +: 2];
          m_be_n    = ~m_be;
          m_dat     = bus.m_writedata[g*DW +: DW];
          if (m_wr) begin
            nw = ref_get(m_addr);
            for (int b = 0; b < 2; b++) if (m_be[b]) nw[b*8 +: 8] = m_dat[b*8 +: 8];
            ref_mem[m_addr] = nw;
          end else begin
            m_exp_rd = ref_get(m_addr);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_all();
    bus.m_read  = '0;
    bus.m_write = '0;
  endtask

  task automatic set_req(input int i, input logic rd, input logic wr, input logic [19:0] a,
                         input logic [1:0] be, input logic [15:0] d);
    bus.m_read[i]              = rd;
    bus.m_write[i]             = wr;
    bus.m_address[i*AW +: AW]  = a;
    bus.m_byteenable[i*2 +: 2] = be;
    bus.m_writedata[i*DW +: DW] = d;
  endtask

  int got[$];
  int exp3[6] = '{0, 1, 2, 3, 0, 1};
  int acc0, acc3, rdy_cnt;
  logic found;
  logic [15:0] rdat;

  initial begin
    bus.lock_en = 1'b0;
    bus.lock_sel = '0;
    bus.m_address = '0;
    bus.m_byteenable = '0;
    bus.m_writedata = '0;
    clr_all();
    sram_mem[20'h00010] = 16'hBEEF;
    ref_mem[20'h00010]  = 16'hBEEF;
    repeat (3) @(negedge clock);
    tick();
    reset_n = 1'b1;
    tick();

    // Single read from master 0.
    set_req(0, 1'b1, 1'b0, 20'h00010, 2'b11, 16'h0);
    @(negedge clock); check("t1_accept_wait", 32'(bus.m_waitrequest), 32'hE);
    tick(); clr_all();
    @(negedge clock); check("t1_oe_rd1", 32'(sram_oe_n), 32'd0);
    tick();
    @(negedge clock); check("t1_oe_rd2", 32'(sram_oe_n), 32'd0);
    check("t1_no_rdy_early", 32'(bus.m_readdataready), 32'd0);
    tick();
    @(negedge clock); check("t1_rdy", 32'(bus.m_readdataready), 32'h1);
    check("t1_rdata", 32'(bus.m_readdata), 32'hBEEF);
    check("t1_oe_off", 32'(sram_oe_n), 32'd1);

    // Upper-byte write from master 2 at the top address, then read it back.
    tick();
    set_req(2, 1'b0, 1'b1, 20'hFFFFF, 2'b10, 16'h1234);
    @(negedge clock); check("t2_accept_wait", 32'(bus.m_waitrequest), 32'hB);
    tick(); clr_all();
    @(negedge clock); check("t2_we_wr1", 32'(sram_we_n), 32'd0);
    check("t2_be_n", 32'(sram_be_n), 32'h1);
    check("t2_data_wr1", 32'(sram_data), 32'h1234);
    tick();
    @(negedge clock); check("t2_we_wr2", 32'(sram_we_n), 32'd0);
    tick();
    @(negedge clock); check("t2_we_hold", 32'(sram_we_n), 32'd1);
    check("t2_ce_hold", 32'(sram_ce_n), 32'd0);
    check("t2_data_hold", 32'(sram_data), 32'h1234);
    tick();
    @(negedge clock); check("t2_idle", 32'(bus.busy), 32'd0);
    tick();
    set_req(2, 1'b1, 1'b0, 20'hFFFFF, 2'b11, 16'h0);
    @(negedge clock);
    tick(); clr_all();
    tick(); tick();
    @(negedge clock); check("t2_rb_rdy", 32'(bus.m_readdataready), 32'h4);
    rdat = bus.m_readdata;
    check("t2_rb_hi", 32'(rdat[15:8]), 32'h12);

    // Round-robin fairness from reset with all masters reading.
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    tick();
    for (int i = 0; i < NM; i++) set_req(i, 1'b1, 1'b0, 20'(20'h100 + i), 2'b11, 16'h0);
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      @(negedge clock);
      for (int i = 0; i < NM; i++) if (!bus.m_waitrequest[i]) got.push_back(i);
    end
    check("t3_grant_count", 32'(got.size()), 32'd6);
    for (int k = 0; k < 6 && k < got.size(); k++) check("t3_grant_order", 32'(got[k]), 32'(exp3[k]));
    tick(); clr_all();
    repeat (4) tick();

    // Lock to master 3 while master 0 also requests.
    bus.lock_en = 1'b1;
    bus.lock_sel = 2'd3;
    set_req(0, 1'b1, 1'b0, 20'h00011, 2'b11, 16'h0);
    set_req(3, 1'b1, 1'b0, 20'h00012, 2'b11, 16'h0);
    acc0 = 0; acc3 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!bus.m_waitrequest[0]) acc0++;
      if (!bus.m_waitrequest[3]) acc3++;
    end
    check("t4_master0_locked_out", 32'(acc0), 32'd0);
    check("t4_master3_served", 32'(acc3 > 0), 32'd1);
    tick();
    bus.lock_en = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clock);
      if (!bus.m_waitrequest[0]) found = 1'b1;
    end
    check("t4_master0_after_unlock", 32'(found), 32'd1);
    tick(); clr_all();
    repeat (5) tick();

    // Reset during the second read cycle aborts the read.
    set_req(1, 1'b1, 1'b0, 20'h00010, 2'b11, 16'h0);
    @(negedge clock); check("t5_accept_wait", 32'(bus.m_waitrequest), 32'hD);
    tick(); clr_all();
    tick();
    reset_n = 1'b0;
    #1;
    check("t5_oe_abort", 32'(sram_oe_n), 32'd1);
    check("t5_ce_abort", 32'(sram_ce_n), 32'd1);
    check("t5_busy_abort", 32'(bus.busy), 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (bus.m_readdataready != 0) rdy_cnt++;
    end
    check("t5_no_rdy", 32'(rdy_cnt), 32'd0);
    tick();
    set_req(1, 1'b1, 1'b0, 20'h00010, 2'b11, 16'h0);
    @(negedge clock);
    tick(); clr_all();
    tick(); tick();
    @(negedge clock); check("t5_post_rdy", 32'(bus.m_readdataready), 32'h2);
    check("t5_post_rdata", 32'(bus.m_readdata), 32'hBEEF);

    // Simultaneous read and write: the write wins.
    tick();
    set_req(1, 1'b1, 1'b1, 20'h00040, 2'b11, 16'hCAFE);
    @(negedge clock); check("t6_accept_wait", 32'(bus.m_waitrequest), 32'hD);
    tick(); clr_all();
    @(negedge clock); check("t6_we", 32'(sram_we_n), 32'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (bus.m_readdataready != 0) rdy_cnt++;
    end
    check("t6_no_rdy", 32'(rdy_cnt), 32'd0);
    tick();
    set_req(1, 1'b1, 1'b0, 20'h00040, 2'b11, 16'h0);
    @(negedge clock);
    tick(); clr_all();
    tick(); tick();
    @(negedge clock); check("t6_rb_rdata", 32'(bus.m_readdata), 32'hCAFE);

    // Random traffic: masters hold requests until accepted; lock toggles occasionally.
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < NM; i++) begin
        if (acc_mask[i]) begin
          bus.m_read[i]  = 1'b0;
          bus.m_write[i] = 1'b0;
        end
        if (!bus.m_read[i] && !bus.m_write[i] && $urandom_range(0, 2) == 0) begin
          int r;
          r = int'($urandom_range(0, 9));
          set_req(i, (r < 5) || (r == 9), (r >= 5),
                  ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'(20'h10 + $urandom_range(0, 7)),
                  2'($urandom_range(1, 3)), 16'($urandom));
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        bus.lock_en  = ($urandom_range(0, 2) == 0);
        bus.lock_sel = 2'($urandom_range(0, 3));
      end
    end
    clr_all();
    bus.lock_en = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
